// File: rtl/ysyx_25030093_dmem_resp.sv
// Data-memory responder: one outstanding load/store and a word-organised SRAM model.
// A programmable delay sits between request acceptance and the response handshake.
module ysyx_25030093_dmem_resp #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        wen_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH];

  // With LATENCY=1 the access commits on the acceptance edge, so it must use the live inputs.
  logic        a_wen;
  logic [1:0]  a_size;
  logic        a_uns;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        in_idle;

  assign in_idle = (state_q == StIdle);
  assign a_wen   = in_idle ? req_wen      : wen_q;
  assign a_size  = in_idle ? req_size     : size_q;
  assign a_uns   = in_idle ? req_unsigned : uns_q;
  assign a_addr  = in_idle ? req_addr     : addr_q;
  assign a_wdata = in_idle ? req_wdata    : wdata_q;

  // 33-bit offset: addresses below BASE go negative and land far outside SPAN.
  logic [32:0]   off;
  logic [AW-1:0] widx;
  logic          misalign;
  logic          err;
  logic          commit;

  assign off      = {1'b0, a_addr} - {1'b0, BASE};
  assign widx     = off[AW+1:2];
  assign misalign = ((a_size == 2'd1) && off[0]) || ((a_size == 2'd2) && (off[1:0] != 2'b00));
  assign err      = (off >= SPAN) || (a_size == 2'd3) || misalign;
  assign commit   = (in_idle && req_valid && (LATENCY == 1)) ||
                    ((state_q == StWait) && (cnt_q == 4'd0));

  logic [31:0] rword;
  logic [15:0] lane_word;
  logic [31:0] load_data;
  logic [3:0]  be;
  logic [31:0] wd_shift;
  logic [31:0] new_word;

  assign rword = mem[widx];

  always_comb begin
    lane_word = 16'(rword >> {off[1:0], 3'b000});
    wd_shift  = a_wdata << {off[1:0], 3'b000};
    load_data = rword;
    be        = 4'b1111;
    case (a_size)
      2'd0: begin
        load_data = a_uns ? {24'b0, lane_word[7:0]} : {{24{lane_word[7]}}, lane_word[7:0]};
        be        = 4'b0001 << off[1:0];
      end
      2'd1: begin
        load_data = a_uns ? {16'b0, lane_word} : {{16{lane_word[15]}}, lane_word};
        be        = 4'b0011 << off[1:0];
      end
      default: ;
    endcase
    new_word = rword;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) new_word[8*i +: 8] = wd_shift[8*i +: 8];
    end
  end

  // A reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (commit && a_wen && !err && !rst) mem[widx] <= new_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            wen_q   <= req_wen;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= 4'(LATENCY - 1);
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) state_q <= StResp;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        StResp: begin
          if (resp_ready) begin
            state_q <= StIdle;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (commit) begin
        rdata_q <= (err || a_wen) ? 32'd0 : load_data;
        err_q   <= err;
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_25030093_dmem_resp.sv
// Bench for the data-memory responder: three instances (LATENCY 2, 4, 1) checked
// against a byte-addressed reference model of the low 64 bytes of each memory.
module tb_ysyx_25030093_dmem_resp;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst          [3];
  logic        req_valid    [3];
  logic        req_ready    [3];
  logic        req_wen      [3];
  logic [1:0]  req_size     [3];
  logic        req_unsigned [3];
  logic [31:0] req_addr     [3];
  logic [31:0] req_wdata    [3];
  logic        resp_valid   [3];
  logic        resp_ready   [3];
  logic [31:0] resp_rdata   [3];
  logic        resp_err     [3];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [7:0] mdl [3][64];

  always #5 clk = ~clk;

  ysyx_25030093_dmem_resp #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  ysyx_25030093_dmem_resp #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  ysyx_25030093_dmem_resp #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
    .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Edges from acceptance until resp_valid is seen: LATENCY=1 answers on the accept edge.
  function automatic int exp_lat(input int k);
    return (k == 0) ? 2 : (k == 1) ? 4 : 0;
  endfunction

  // Reference: byte-granular memory, error rules from address range / size / alignment.
  function automatic void model(input int k, input bit wen, input logic [1:0] size,
                                input bit uns, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd,
                                output bit err);
    longint off = longint'(addr) - longint'(BASE);
    int n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    logic [31:0] v = 32'd0;
    rd  = 32'd0;
    err = (off < 0) || (off >= 4 * DEPTH) || (size == 2'd3) || ((addr % n) != 0);
    if (err) return;
    for (int i = 0; i < n; i++) begin
      if (wen) mdl[k][int'(off) + i] = wdata[8*i +: 8];
      else     v = v | (32'(mdl[k][int'(off) + i]) << (8 * i));
    end
    if (!wen) begin
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      rd = v;
    end
  endfunction

  task automatic drive(input int k, input bit wen, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_wen[k] = wen; req_size[k] = size; req_unsigned[k] = uns;
    req_addr[k] = addr; req_wdata[k] = wdata;
  endtask

  task automatic do_req(input int k, input bit wen, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd_exp, input bit err_exp, input string tag);
    int n = 0;
    chk({tag, " req_ready"}, 32'(req_ready[k]), 32'd1);
    drive(k, wen, size, uns, addr, wdata);
    req_valid[k] = 1'b1;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    // Fields change after acceptance and must not matter.
    drive(k, ~wen, 2'($urandom), 1'($urandom), $urandom, $urandom);
    while (!resp_valid[k] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat(k)));
    chk({tag, " rdata"}, resp_rdata[k], rd_exp);
    chk({tag, " err"}, 32'(resp_err[k]), 32'(err_exp));
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
    chk({tag, " back_idle"}, {30'd0, resp_valid[k], req_ready[k]}, 32'd1);
    chk({tag, " cleared"}, {resp_rdata[k][30:0], resp_err[k]}, 32'd0);
  endtask

  task automatic xact(input int k, input bit wen, input logic [1:0] size, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    logic [31:0] rd;
    bit e;
    model(k, wen, size, uns, addr, wdata, rd, e);
    do_req(k, wen, size, uns, addr, wdata, rd, e, tag);
  endtask

  task automatic rand_op(input int k, input bit allow_fault, output bit wen,
                         output logic [1:0] size, output bit uns, output logic [31:0] addr,
                         output logic [31:0] wdata);
    logic [31:0] bad [4] = '{BASE - 32'd4, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFC, 32'd0};
    wen   = 1'($urandom);
    uns   = 1'($urandom);
    wdata = $urandom;
    size  = 2'($urandom_range(0, 2));
    addr  = BASE + 32'($urandom_range(0, 63));
    if (!allow_fault) begin
      addr = addr & (size == 2'd2 ? ~32'd3 : size == 2'd1 ? ~32'd1 : ~32'd0);
    end else begin
      if ($urandom_range(0, 15) == 0) size = 2'd3;
      if ($urandom_range(0, 7) == 0) addr = bad[$urandom_range(0, 3)];
    end
  endtask

  initial begin
    logic [31:0] rd, held, addr, wdata;
    logic [1:0]  size;
    bit          e, wen, uns;
    int          seen;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; resp_ready[k] = 1'b0;
      drive(k, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0;
      chk($sformatf("reset%0d", k),
          {resp_rdata[k][29:0], resp_err[k], resp_valid[k]}, 32'd0);
      chk($sformatf("reset%0d ready", k), 32'(req_ready[k]), 32'd1);
    end

    // Fill the modelled region so later loads read defined data.
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++)
        xact(k, 1'b1, 2'd2, 1'b0, BASE + 32'(4 * w), $urandom, $sformatf("init%0d", k));

    xact(0, 1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, "sw");
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, "lw");
    model(0, 1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'd0, rd, e);
    xact(0, 1'b1, 2'd0, 1'b0, 32'h8000_0011, 32'h0000_0012, "sb");
    do_req(0, 1'b0, 2'd0, 1'b0, 32'h8000_0011, 32'd0, 32'h0000_0012, 1'b0, "lb");
    do_req(0, 1'b0, 2'd0, 1'b1, 32'h8000_0010, 32'd0, 32'h0000_00EF, 1'b0, "lbu");
    do_req(0, 1'b0, 2'd1, 1'b0, 32'h8000_0012, 32'd0, 32'hFFFF_DEAD, 1'b0, "lh");
    do_req(0, 1'b0, 2'd1, 1'b1, 32'h8000_0012, 32'd0, 32'h0000_DEAD, 1'b0, "lhu");
    xact(0, 1'b1, 2'd1, 1'b0, 32'h8000_0010, 32'h0000_8001, "sh");
    do_req(0, 1'b0, 2'd1, 1'b0, 32'h8000_0010, 32'd0, 32'hFFFF_8001, 1'b0, "lh2");
    do_req(0, 1'b0, 2'd2, 1'b1, 32'h8000_0010, 32'd0, 32'hDEAD_8001, 1'b0, "lw2");

    do_req(0, 1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'd0, 32'd0, 1'b1, "lw_misal");
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h7FFF_FFFC, 32'h1234_5678, 32'd0, 1'b1, "sw_below");
    do_req(0, 1'b0, 2'd2, 1'b0, BASE + 32'(4 * DEPTH), 32'd0, 32'd0, 1'b1, "lw_end");
    do_req(0, 1'b0, 2'd3, 1'b0, 32'h8000_0010, 32'd0, 32'd0, 1'b1, "size3");
    do_req(0, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b1, "lw_wrap");
    do_req(0, 1'b0, 2'd1, 1'b0, 32'h8000_0011, 32'd0, 32'd0, 1'b1, "lh_misal");
    do_req(0, 1'b1, 2'd1, 1'b0, 32'h8000_0013, 32'h0000_FFFF, 32'd0, 1'b1, "sh_misal");
    do_req(0, 1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'd0, 32'hDEAD_8001, 1'b0, "lw_after_f");
    do_req(0, 1'b1, 2'd2, 1'b0, BASE + 32'(4 * DEPTH - 4), 32'hA5A5_0001, 32'd0, 1'b0,
           "sw_last");
    do_req(0, 1'b0, 2'd2, 1'b0, BASE + 32'(4 * DEPTH - 4), 32'd0, 32'hA5A5_0001, 1'b0,
           "lw_last");

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 40; i++) begin
        rand_op(k, 1'b1, wen, size, uns, addr, wdata);
        xact(k, wen, size, uns, addr, wdata, $sformatf("rnd%0d_%0d", k, i));
      end

    // Backpressure: response held, a stray store pulse must be ignored.
    model(0, 1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'd0, rd, e);
    drive(0, 1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'd0);
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    seen = 0;
    while (!resp_valid[0] && seen < 40) begin
      @(posedge clk); #1;
      seen++;
    end
    held = resp_rdata[0];
    chk("bp first", held, rd);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        drive(0, 1'b1, 2'd2, 1'b0, 32'h8000_0014, 32'hFFFF_FFFF);
        req_valid[0] = 1'b1;
      end
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      chk($sformatf("bp valid%0d", c), {30'd0, resp_valid[0], req_ready[0]}, 32'd2);
      chk($sformatf("bp rdata%0d", c), resp_rdata[0], rd);
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    chk("bp release", {30'd0, resp_valid[0], req_ready[0]}, 32'd1);
    xact(0, 1'b0, 2'd2, 1'b0, 32'h8000_0014, 32'd0, "bp ignored");

    // Reset two edges after acceptance (LATENCY=4): store is abandoned.
    xact(1, 1'b1, 2'd2, 1'b0, 32'h8000_0020, 32'h1122_3344, "pre_rst sw");
    drive(1, 1'b1, 2'd2, 1'b0, 32'h8000_0020, 32'h55AA_55AA);
    req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    chk("midrst state", {29'd0, resp_err[1], resp_valid[1], req_ready[1]}, 32'd1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (resp_valid[1]) seen++;
    end
    chk("midrst no_resp", 32'(seen), 32'd0);
    xact(1, 1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'd0, "midrst lw");

    // LATENCY=1 back-to-back with resp_ready tied high: one response every 2 cycles.
    resp_ready[2] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_op(2, 1'b0, wen, size, uns, addr, wdata);
      model(2, wen, size, uns, addr, wdata, rd, e);
      drive(2, wen, size, uns, addr, wdata);
      req_valid[2] = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d resp", i), {30'd0, resp_valid[2], req_ready[2]}, 32'd2);
      chk($sformatf("b2b%0d rdata", i), {resp_rdata[2]}, rd);
      chk($sformatf("b2b%0d err", i), 32'(resp_err[2]), 32'(e));
      drive(2, 1'b1, 2'd2, 1'b0, BASE + 32'h30, $urandom);
      @(posedge clk); #1;
      chk($sformatf("b2b%0d idle", i), {30'd0, resp_valid[2], req_ready[2]}, 32'd1);
    end
    req_valid[2] = 1'b0;
    resp_ready[2] = 1'b0;
    xact(2, 1'b0, 2'd2, 1'b0, BASE + 32'h30, 32'd0, "b2b check");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
